// File: rtl/reset_sequencer.sv
// Ordered subsystem reset release: waits for PLL lock, then releases each stage after a hold gap and its ack.
// Optional ack timeout with sticky error and full retry: define RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int unsigned STAGES         = 4,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] stage_reset,
  output logic              all_released,
  output logic              seq_error,
  output logic [2:0]        stage_idx
);

  localparam int unsigned CNT_SPAN = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW       = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;
  localparam int unsigned IW       = 3;

  if (STAGES < 1 || STAGES > 8 || HOLD_CYCLES == 0) begin : g_param_check
    $error("reset_sequencer: STAGES must be 1..8 and HOLD_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    WAIT_ACK,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic [IW-1:0]     idx_d;
  logic [STAGES-1:0] sr_d;
  logic [STAGES-1:0] rel_mask;
  logic              err_d;
  logic              ack_sel;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  // Next-state and next-output logic; lock loss overrides everything except seq_error.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = stage_idx;
    sr_d     = stage_reset;
    err_d    = seq_error;
    ack_sel  = 1'b0;
    rel_mask = '0;

    for (int i = 0; i < int'(STAGES); i++) begin
      if (stage_idx == IW'(i)) begin
        ack_sel     = stage_ack[i];
        rel_mask[i] = 1'b1;
      end
    end

    if (!pll_locked) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      sr_d    = '1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            sr_d    = stage_reset & ~rel_mask;
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_ACK: begin
          if (ack_sel) begin
            cnt_d = '0;
            // With STAGES=8 the 3-bit index reads 0 in DONE.
            if (stage_idx == IW'(STAGES - 1)) begin
              idx_d   = IW'(STAGES);
              state_d = DONE;
            end else begin
              idx_d   = stage_idx + IW'(1);
              state_d = HOLD;
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            sr_d    = '1;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = WAIT_LOCK;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
        DONE:    state_d = DONE;
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      stage_idx    <= '0;
      stage_reset  <= '1;
      all_released <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_idx    <= idx_d;
      stage_reset  <= sr_d;
      all_released <= ~|sr_d;
      seq_error    <= err_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (STAGES=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=16) with a release-count model.
module tb_reset_sequencer;

  localparam int S   = 3;
  localparam int H   = 4;
  localparam int TCY = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         pll_locked;
  logic [S-1:0] stage_ack;
  logic [S-1:0] stage_reset;
  logic         all_released;
  logic         seq_error;
  logic [2:0]   stage_idx;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .STAGES        (S),
    .HOLD_CYCLES   (H),
    .TIMEOUT_CYCLES(TCY)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .stage_ack   (stage_ack),
    .stage_reset (stage_reset),
    .all_released(all_released),
    .seq_error   (seq_error),
    .stage_idx   (stage_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of stages released so far, edges since the last event, and whether an ack is pending.
  int m_rel, m_cnt;
  bit m_active, m_ackwait, m_err, m_valid;

  always @(posedge clock) begin
    if (reset) begin
      m_rel = 0; m_cnt = 0; m_active = 0; m_ackwait = 0; m_err = 0; m_valid = 1;
    end else if (!pll_locked) begin
      m_rel = 0; m_cnt = 0; m_active = 0; m_ackwait = 0;
    end else if (!m_active) begin
      m_active = 1; m_cnt = 0;
    end else if (m_ackwait) begin
      if (stage_ack[m_rel-1]) begin
        m_ackwait = 0; m_cnt = 0;
      end
`ifdef RESET_SEQ_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TCY) begin
          m_err = 1; m_rel = 0; m_active = 0; m_ackwait = 0; m_cnt = 0;
        end
      end
`endif
    end else if (m_rel < S) begin
      m_cnt++;
      if (m_cnt == H) begin
        m_rel++; m_ackwait = 1; m_cnt = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [S-1:0] ones;
    logic [S-1:0] exp_sr;
    int           exp_idx;
    if (m_valid) begin
      ones    = '1;
      exp_sr  = ones << m_rel;
      exp_idx = m_ackwait ? m_rel - 1 : m_rel;
      chk("model_stage_reset", 32'(stage_reset), 32'(exp_sr));
      chk("model_all_released", 32'(all_released), 32'(m_rel == S));
      chk("model_stage_idx", 32'(stage_idx), 32'(exp_idx));
      chk("model_seq_error", 32'(seq_error), 32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b1; stage_ack = 3'b111;
    step(3);
    chk("rst_stage_reset", 32'(stage_reset), 32'h7);
    chk("rst_all_released", 32'(all_released), 32'h0);
    chk("rst_stage_idx", 32'(stage_idx), 32'h0);
    chk("rst_seq_error", 32'(seq_error), 32'h0);

    // Basic ordered release: releases at t5, t10, t15.
    reset = 1'b0;
    step(4);  chk("s1_t4", 32'(stage_reset), 32'h7);
    step(1);  chk("s1_t5", 32'(stage_reset), 32'h6);
    step(4);  chk("s1_t9", 32'(stage_reset), 32'h6);
    step(1);  chk("s1_t10", 32'(stage_reset), 32'h4);
    step(4);  chk("s1_t14", 32'(stage_reset), 32'h4);
    step(1);  chk("s1_t15", 32'(stage_reset), 32'h0);
              chk("s1_t15_all", 32'(all_released), 32'h1);
    step(1);  chk("s1_done_idx", 32'(stage_idx), 32'h3);

    // Lock loss in DONE, then identical replay.
    pll_locked = 1'b0;
    step(1);  chk("s3_drop_sr", 32'(stage_reset), 32'h7);
              chk("s3_drop_all", 32'(all_released), 32'h0);
              chk("s3_drop_idx", 32'(stage_idx), 32'h0);
    pll_locked = 1'b1;
    step(4);  chk("s3_t4", 32'(stage_reset), 32'h7);
    step(1);  chk("s3_t5", 32'(stage_reset), 32'h6);
    step(5);  chk("s3_t10", 32'(stage_reset), 32'h4);
    step(5);  chk("s3_t15", 32'(stage_reset), 32'h0);
    step(1);  chk("s3_done_idx", 32'(stage_idx), 32'h3);

    // Ack stall on stage 1 for 20 edges after its release.
    pll_locked = 1'b0; step(1); pll_locked = 1'b1; stage_ack = 3'b101;
    step(5);  chk("s2_t5", 32'(stage_reset), 32'h6);
    step(5);  chk("s2_t10", 32'(stage_reset), 32'h4);
    step(20); chk("s2_stall_sr", 32'(stage_reset), 32'h4);
              chk("s2_stall_idx", 32'(stage_idx), 32'h1);
`ifndef RESET_SEQ_TIMEOUT_EN
              chk("s2_no_timeout", 32'(seq_error), 32'h0);
`endif
    stage_ack = 3'b111;
    step(4);  chk("s2_t34", 32'(stage_reset), 32'h4);
    step(1);  chk("s2_t35", 32'(stage_reset), 32'h0);
    step(2);  chk("s2_done_idx", 32'(stage_idx), 32'h3);

    // Lock loss while holding before stage 1; counter restarts.
    pll_locked = 1'b0; step(1); pll_locked = 1'b1;
    step(5);  chk("s4_t5", 32'(stage_reset), 32'h6);
    step(2);  chk("s4_hold_idx", 32'(stage_idx), 32'h1);
    pll_locked = 1'b0;
    step(1);  chk("s4_drop_sr", 32'(stage_reset), 32'h7);
              chk("s4_drop_idx", 32'(stage_idx), 32'h0);
    pll_locked = 1'b1;
    step(4);  chk("s4_t12", 32'(stage_reset), 32'h7);
    step(1);  chk("s4_t13", 32'(stage_reset), 32'h6);
    stage_ack = 3'b001;
    step(5);  chk("s4_t18", 32'(stage_reset), 32'h4);

    // Reset while stalled in WAIT_ACK for stage 1.
    step(2);  chk("s5_stalled", 32'(stage_idx), 32'h1);
    reset = 1'b1;
    step(1);  chk("s5_sr", 32'(stage_reset), 32'h7);
              chk("s5_all", 32'(all_released), 32'h0);
              chk("s5_idx", 32'(stage_idx), 32'h0);
              chk("s5_err", 32'(seq_error), 32'h0);
    reset = 1'b0;

`ifdef RESET_SEQ_TIMEOUT_EN
    // Timeout on stage 0, retry, then ack on the timeout edge wins.
    stage_ack = 3'b000;
    step(5);  chk("s6_t5", 32'(stage_reset), 32'h6);
    step(15); chk("s6_t20_sr", 32'(stage_reset), 32'h6);
              chk("s6_t20_err", 32'(seq_error), 32'h0);
    step(1);  chk("s6_t21_sr", 32'(stage_reset), 32'h7);
              chk("s6_t21_err", 32'(seq_error), 32'h1);
    step(5);  chk("s6_t26", 32'(stage_reset), 32'h6);
    step(15); stage_ack = 3'b001;
    step(1);  chk("s6_ackwin_idx", 32'(stage_idx), 32'h1);
              chk("s6_ackwin_sr", 32'(stage_reset), 32'h6);
              chk("s6_ackwin_err", 32'(seq_error), 32'h1);
`else
    stage_ack = 3'b111;
    step(20); chk("s6_done_idx", 32'(stage_idx), 32'h3);
              chk("s6_err_zero", 32'(seq_error), 32'h0);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
